pci_arbiter: RTL and testbench

PCI_ARBITER -- requirements
Module: pci_arbiter

---
 rtl/pci_arb_pkg.sv | 14 +
 rtl/pci_arb_if.sv | 28 ++
 rtl/pci_arb_rr_pick.sv | 26 ++
 rtl/pci_arbiter.sv | 132 +++++++++++++
 tb/tb_pci_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pci_arb_pkg.sv
// rtl/pci_arb_pkg.sv - shared FSM state type and default sizing for the PCI arbiter
package pci_arb_pkg;

    localparam int NMASTER_DEF     = 4;
    localparam int GNT_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        BUSY     = 2'd2,
        HANDOVER = 2'd3
    } arb_state_t;

endpackage

// File: rtl/pci_arb_if.sv
// rtl/pci_arb_if.sv - request/grant and bus-status bundle between arbiter and PCI agents
interface pci_arb_if
    import pci_arb_pkg::*;
#(
    parameter int NMASTER = NMASTER_DEF
);
    localparam int OW = (NMASTER > 1) ? $clog2(NMASTER) : 1;

    logic [NMASTER-1:0] req;
    logic [NMASTER-1:0] gnt;
    logic               frame;
    logic               irdy;
    logic [OW-1:0]      owner;
    logic               bus_busy;
    logic               timeout;

    // arbiter side
    modport master (
        input  req, frame, irdy,
        output gnt, owner, bus_busy, timeout
    );

    // bus agent side
    modport slave (
        output req, frame, irdy,
        input  gnt, owner, bus_busy, timeout
    );
endinterface

// File: rtl/pci_arb_rr_pick.sv
// rtl/pci_arb_rr_pick.sv - combinational round-robin search from a start index with wrap
module pci_arb_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] act,
    input  logic [W-1:0] start,
    input  logic [N-1:0] excl,
    output logic [W-1:0] win,
    output logic         valid
);
    // Walk downward so the last hit written is the one closest to start.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int idx;
            idx = int'(start) + i;
            if (idx >= N) idx = idx - N;
            if (act[idx] && !excl[idx]) begin
                valid = 1'b1;
                win   = W'(idx);
            end
        end
    end
endmodule

// File: rtl/pci_arbiter.sv
// rtl/pci_arbiter.sv - PCI round-robin bus arbiter with hidden arbitration; PCI_ARB_PARK_EN parks grant on owner
module pci_arbiter
    import pci_arb_pkg::*;
#(
    parameter int NMASTER     = NMASTER_DEF,
    parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    pci_arb_if.master     bus
);
    localparam int OW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
    localparam int CW = $clog2(GNT_TIMEOUT + 1);

    arb_state_t         state, state_nxt;
    logic [NMASTER-1:0] gnt_q, gnt_nxt;
    logic [OW-1:0]      owner_q, owner_nxt;
    logic [CW-1:0]      cnt_q, cnt_nxt;
    logic               timeout_q, timeout_nxt;

    logic [NMASTER-1:0] act, excl, owner_bit;
    logic [OW-1:0]      start, win;
    logic               win_valid, bus_idle, owner_req, other_req;

    assign act       = ~bus.req;
    assign bus_idle  = bus.frame & bus.irdy;
    assign owner_bit = NMASTER'(1) << owner_q;
    assign owner_req = act[owner_q];
    assign other_req = |(act & ~owner_bit);
    assign start     = (owner_q == OW'(NMASTER - 1)) ? '0 : owner_q + OW'(1);

    // The owner is skipped during hidden arbitration and right after it timed out.
    assign excl = ((state == BUSY) || (state == HANDOVER && timeout_q)) ? owner_bit : '0;

    pci_arb_rr_pick #(.N(NMASTER), .W(OW)) u_pick (
        .act   (act),
        .start (start),
        .excl  (excl),
        .win   (win),
        .valid (win_valid)
    );

    // State and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_q     <= '1;
            owner_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt_q     <= gnt_nxt;
            owner_q   <= owner_nxt;
            cnt_q     <= cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    // Next-state, grant, owner, idle-grant counter and timeout pulse.
    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt_q;
        owner_nxt   = owner_q;
        cnt_nxt     = cnt_q;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    gnt_nxt   = ~(NMASTER'(1) << win);
                    owner_nxt = win;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!bus.frame) begin
                    state_nxt = BUSY;
                end else if (owner_req) begin
                    if (bus_idle) begin
                        if (cnt_q >= CW'(GNT_TIMEOUT - 1)) begin
                            cnt_nxt     = CW'(GNT_TIMEOUT);
                            timeout_nxt = 1'b1;
                            gnt_nxt     = '1;
                            state_nxt   = HANDOVER;
                        end else begin
                            cnt_nxt = cnt_q + CW'(1);
                        end
                    end
                end else if (other_req) begin
                    gnt_nxt   = '1;
                    state_nxt = HANDOVER;
                end else begin
`ifdef PCI_ARB_PARK_EN
                    cnt_nxt   = '0;
`else
                    gnt_nxt   = '1;
                    state_nxt = IDLE;
`endif
                end
            end
            HANDOVER: begin
                if (win_valid) begin
                    gnt_nxt   = ~(NMASTER'(1) << win);
                    owner_nxt = win;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (bus_idle) begin
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end else if (win_valid) begin
                    gnt_nxt   = ~(NMASTER'(1) << win);
                    owner_nxt = win;
                end
            end
            default: begin
                gnt_nxt   = '1;
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.gnt      = gnt_q;
    assign bus.owner    = owner_q;
    assign bus.bus_busy = (state == BUSY);
    assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_pci_arbiter.sv
// tb/tb_pci_arbiter.sv - directed and randomized bench for pci_arbiter against a behavioural model
module tb_pci_arbiter;
    localparam int N = 4;
    localparam int T = 16;
    localparam int S_IDLE = 0, S_GRANT = 1, S_BUSY = 2, S_HAND = 3;
`ifdef PCI_ARB_PARK_EN
    localparam logic [N-1:0] PARK_EXP = 4'b1011;
`else
    localparam logic [N-1:0] PARK_EXP = 4'b1111;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // behavioural model: grant holder (-1 = none), owner, idle-grant count
    int m_st, m_g, m_own, m_cnt, m_skip;
    bit m_to;

    pci_arb_if #(.NMASTER(N)) bus ();

    pci_arbiter #(.NMASTER(N), .GNT_TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int from, input int skip);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (from + k) % N;
            if (r[idx] == 1'b0 && idx != skip) return idx;
        end
        return -1;
    endfunction

    task automatic give(input int w);
        m_g = w; m_own = w; m_cnt = 0; m_st = S_GRANT;
    endtask

    task automatic model_edge();
        int  w, from;
        bit  idle, others;
        if (rst) begin
            m_st = S_IDLE; m_g = -1; m_own = 0; m_cnt = 0; m_to = 0; m_skip = -1;
            return;
        end
        from   = (m_own + 1) % N;
        idle   = bus.frame && bus.irdy;
        others = 0;
        for (int i = 0; i < N; i++) if (i != m_own && !bus.req[i]) others = 1;
        m_to = 0;
        case (m_st)
            S_IDLE: begin
                w = pick(bus.req, from, -1);
                if (w >= 0) give(w);
            end
            S_GRANT: begin
                if (!bus.frame) m_st = S_BUSY;
                else if (!bus.req[m_own]) begin
                    if (idle) begin
                        m_cnt++;
                        if (m_cnt >= T) begin
                            m_to = 1; m_g = -1; m_skip = m_own; m_st = S_HAND;
                        end
                    end
                end else if (others) begin
                    m_g = -1; m_st = S_HAND;
                end else begin
`ifdef PCI_ARB_PARK_EN
                    m_cnt = 0;
`else
                    m_g = -1; m_st = S_IDLE;
`endif
                end
            end
            S_HAND: begin
                w = pick(bus.req, from, m_skip);
                m_skip = -1;
                if (w >= 0) give(w);
                else m_st = S_IDLE;
            end
            default: begin
                if (idle) begin
                    m_st = S_GRANT; m_cnt = 0;
                end else begin
                    w = pick(bus.req, from, m_own);
                    if (w >= 0) begin m_g = w; m_own = w; end
                end
            end
        endcase
    endtask

    task automatic step();
        logic [N-1:0] eg;
        int           low;
        model_edge();
        @(posedge clk);
        #1;
        eg = '1;
        if (m_g >= 0) eg[m_g] = 1'b0;
        low = 0;
        for (int i = 0; i < N; i++) if (!bus.gnt[i]) low++;
        chk("gnt", bus.gnt, eg);
        chk("owner", bus.owner, m_own);
        chk("bus_busy", bus.bus_busy, (m_st == S_BUSY));
        chk("timeout", bus.timeout, m_to);
        chk("gnt_at_most_one", (low <= 1), 1);
    endtask

    initial begin
        bit           reached;
        logic [N-1:0] r;
        logic         f;
        n_checks = 0; n_fail = 0;
        m_st = S_IDLE; m_g = -1; m_own = 0; m_cnt = 0; m_to = 0; m_skip = -1;
        rst = 1'b1; bus.req = '1; bus.frame = 1'b1; bus.irdy = 1'b1;
        step(); step();
        chk("rst_gnt", bus.gnt, 4'b1111);
        chk("rst_owner", bus.owner, 0);
        rst = 1'b0;

        // first grant from reset goes to master 0
        bus.req = 4'b1110; step();
        chk("first_gnt", bus.gnt, 4'b1110);
        chk("first_owner", bus.owner, 0);

        // transaction starts, then hidden arbitration to master 2
        bus.frame = 1'b0; bus.irdy = 1'b0; step();
        chk("busy", bus.bus_busy, 1);
        bus.req = 4'b1010; step();
        chk("hidden_gnt", bus.gnt, 4'b1011);
        chk("hidden_owner", bus.owner, 2);

        // bus returns idle with no requests: park or release
        bus.req = 4'b1111; bus.frame = 1'b1; bus.irdy = 1'b1; step();
        step();
        chk("park", bus.gnt, PARK_EXP);
        step(); step();

        // master 1 granted and never starts a frame: timeout then hand to master 3
        bus.req = 4'b1101;
        reached = 0;
        for (int i = 0; i < 6 && !reached; i++) begin
            step();
            if (bus.gnt == 4'b1101) reached = 1;
        end
        chk("reach_m1", reached, 1);
        bus.req = 4'b0101;
        for (int i = 0; i < T - 1; i++) step();
        chk("to_hold", bus.gnt, 4'b1101);
        step();
        chk("to_pulse", bus.timeout, 1);
        chk("to_allhigh", bus.gnt, 4'b1111);
        step();
        chk("to_next", bus.gnt, 4'b0111);
        chk("to_once", bus.timeout, 0);

        // owner 1 drops its request while 3 still requests
        bus.req = 4'b1101; step(); step();
        chk("m1_again", bus.gnt, 4'b1101);
        bus.req = 4'b0101; step(); step(); step();
        bus.req = 4'b0111; step();
        chk("drop_allhigh", bus.gnt, 4'b1111);
        step();
        chk("drop_next", bus.gnt, 4'b0111);

        // reset in the middle of a transaction
        bus.frame = 1'b0; bus.irdy = 1'b0; step();
        chk("pre_rst_busy", bus.bus_busy, 1);
        rst = 1'b1; step();
        chk("mid_rst_gnt", bus.gnt, 4'b1111);
        chk("mid_rst_owner", bus.owner, 0);
        chk("mid_rst_busy", bus.bus_busy, 0);
        rst = 1'b0; bus.frame = 1'b1; bus.irdy = 1'b1; bus.req = '1; step();

        // randomized traffic with sticky requests and bursty frames
        f = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            r = bus.req;
            for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            if ($urandom_range(0, 5) == 0) f = ~f;
            bus.req   = r;
            bus.frame = f;
            bus.irdy  = f ? ($urandom_range(0, 15) != 0) : logic'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
